// File: rtl/config_frame_sequencer.sv
// Bitstream sequencer: hunts for the sync word, then turns address/row words into
// frame-register writes followed by a one-cycle LongFrameStrobe commit.
module config_frame_sequencer #(
    parameter int unsigned NumberOfRows     = 8,
    parameter int unsigned FrameBitsPerRow  = 32,
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned RowSelectWidth   = 5,
    parameter int unsigned desync_flag      = 20,
    parameter logic [FrameBitsPerRow-1:0] SyncWord = 32'hFAB0FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FrameBitsPerRow-1:0] in_data,
    output logic [FrameBitsPerRow-1:0] ConfigWriteData,
    output logic                       ConfigWriteStrobe,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    output logic                       LongFrameStrobe,
    output logic                       Active,
    output logic [15:0]                FrameCount
);

    // The column and one-hot frame fields must both fit in an address word.
    if ((2 ** RowSelectWidth) <= NumberOfRows ||
        (MaxFramesPerCol + FrameSelectWidth) > FrameBitsPerRow) begin : gBadParams
        $error("config_frame_sequencer: inconsistent row/frame field widths");
    end

    typedef enum logic [1:0] {
        Hunt,
        Addr,
        Data,
        Strobe
    } seqState_t;

    localparam logic [RowSelectWidth-1:0]   LastRow    = RowSelectWidth'(NumberOfRows);
    localparam logic [FrameSelectWidth-1:0] DesyncCode = FrameSelectWidth'(desync_flag);

    seqState_t                   state;
    logic [RowSelectWidth-1:0]   rowCount;
    logic                        accept;
    logic [FrameSelectWidth-1:0] columnField;

    assign accept      = in_valid && in_ready;
    assign columnField = in_data[FrameBitsPerRow-1 -: FrameSelectWidth];

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state                <= Hunt;
            rowCount             <= '0;
            in_ready             <= 1'b1;
            ConfigWriteData      <= '0;
            ConfigWriteStrobe    <= 1'b0;
            RowSelect            <= '0;
            FrameAddressRegister <= '0;
            LongFrameStrobe      <= 1'b0;
            Active               <= 1'b0;
            FrameCount           <= '0;
        end else begin
            ConfigWriteStrobe <= 1'b0;
            RowSelect         <= '0;
            LongFrameStrobe   <= 1'b0;
            case (state)
                Hunt: begin
                    if (accept && in_data == SyncWord) begin
                        state  <= Addr;
                        Active <= 1'b1;
                    end
                end
                Addr: begin
                    if (accept) begin
                        if (columnField == DesyncCode) begin
                            state  <= Hunt;
                            Active <= 1'b0;
                        end else begin
                            FrameAddressRegister <= in_data;
                            rowCount             <= RowSelectWidth'(1);
                            state                <= Data;
                        end
                    end
                end
                Data: begin
                    if (accept) begin
                        ConfigWriteData   <= in_data;
                        RowSelect         <= rowCount;
                        ConfigWriteStrobe <= 1'b1;
                        rowCount          <= rowCount + RowSelectWidth'(1);
                        // Drop ready now so the commit cycle cannot swallow a word.
                        if (rowCount == LastRow) begin
                            state    <= Strobe;
                            in_ready <= 1'b0;
                        end
                    end
                end
                Strobe: begin
                    LongFrameStrobe <= 1'b1;
                    FrameCount      <= FrameCount + 16'd1;
                    in_ready        <= 1'b1;
                    state           <= Addr;
                end
                default: state <= Hunt;
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Randomised bench for config_frame_sequencer against a word-stream reference model.
module tb_config_frame_sequencer;

    localparam int          Rows = 8;
    localparam logic [31:0] Sync = 32'hFAB0FAB1;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] ConfigWriteData;
    logic        ConfigWriteStrobe;
    logic [4:0]  RowSelect;
    logic [31:0] FrameAddressRegister;
    logic        LongFrameStrobe;
    logic        Active;
    logic [15:0] FrameCount;

    config_frame_sequencer #(
        .NumberOfRows    (8),
        .FrameBitsPerRow (32),
        .MaxFramesPerCol (20),
        .FrameSelectWidth(5),
        .RowSelectWidth  (5),
        .desync_flag     (20),
        .SyncWord        (Sync)
    ) dut (
        .CLK                 (CLK),
        .resetn              (resetn),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .ConfigWriteData     (ConfigWriteData),
        .ConfigWriteStrobe   (ConfigWriteStrobe),
        .RowSelect           (RowSelect),
        .FrameAddressRegister(FrameAddressRegister),
        .LongFrameStrobe     (LongFrameStrobe),
        .Active              (Active),
        .FrameCount          (FrameCount)
    );

    always #5 CLK = ~CLK;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model: position in the word stream plus expected outputs.
    bit          hunting;
    int          nextRow;      // 0 = expecting an address word, else next row number
    bit          commitDue;
    logic        expReady, expWr, expLfs, expActive;
    logic [4:0]  expRow;
    logic [31:0] expData, expFar;
    logic [15:0] expCount;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelEdge(input logic rstn, input logic v, input logic [31:0] d);
        logic acc;
        acc    = v && expReady;
        expWr  = 1'b0;
        expRow = '0;
        expLfs = 1'b0;
        if (!rstn) begin
            hunting   = 1'b1;
            nextRow   = 0;
            commitDue = 1'b0;
            expData   = '0;
            expFar    = '0;
            expCount  = '0;
            expReady  = 1'b1;
            expActive = 1'b0;
            return;
        end
        if (commitDue) begin
            commitDue = 1'b0;
            expLfs    = 1'b1;
            expCount  = expCount + 16'd1;
            expReady  = 1'b1;
        end else if (acc) begin
            if (hunting) begin
                hunting = (d != Sync);
            end else if (nextRow == 0) begin
                if (d[31:27] == 5'd20) hunting = 1'b1;
                else begin
                    expFar  = d;
                    nextRow = 1;
                end
            end else begin
                expWr   = 1'b1;
                expRow  = 5'(nextRow);
                expData = d;
                if (nextRow == Rows) begin
                    nextRow   = 0;
                    commitDue = 1'b1;
                    expReady  = 1'b0;
                end else begin
                    nextRow++;
                end
            end
        end
        expActive = !hunting;
    endfunction

    task automatic checkAll();
        checkValue("in_ready", 32'(in_ready), 32'(expReady));
        checkValue("ConfigWriteStrobe", 32'(ConfigWriteStrobe), 32'(expWr));
        checkValue("RowSelect", 32'(RowSelect), 32'(expRow));
        checkValue("ConfigWriteData", ConfigWriteData, expData);
        checkValue("FrameAddressRegister", FrameAddressRegister, expFar);
        checkValue("LongFrameStrobe", 32'(LongFrameStrobe), 32'(expLfs));
        checkValue("Active", 32'(Active), 32'(expActive));
        checkValue("FrameCount", 32'(FrameCount), 32'(expCount));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rstn, input logic v, input logic [31:0] d);
        resetn   = rstn;
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        modelEdge(rstn, v, d);
        #1;
        checkAll();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom);
    endtask

    task automatic sendWord(input logic [31:0] d, input bit gappy);
        bit took;
        if (gappy) idle($urandom_range(0, 2));
        for (int tries = 0; tries < 8; tries++) begin
            took = expReady;
            step(1'b1, 1'b1, d);
            if (took) return;
        end
        checkValue("sendTimeout", 32'd0, 32'd1);
    endtask

    task automatic sendRows(input int n, input bit randomData, input bit gappy);
        for (int r = 1; r <= n; r++)
            sendWord(randomData ? 32'($urandom) : 32'h11 * r, gappy);
    endtask

    initial begin
        logic [31:0] addr;
        @(negedge CLK);

        // Reset, junk in hunt, then sync.
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        sendWord(32'h0, 1'b0);
        sendWord(32'hDEADBEEF, 1'b0);
        checkValue("huntActive", 32'(Active), 32'd0);
        sendWord(Sync, 1'b0);
        checkValue("syncActive", 32'(Active), 32'd1);

        // Back-to-back frame.
        sendWord(32'h0800_0004, 1'b0);
        sendRows(Rows, 1'b0, 1'b0);
        idle(2);
        checkValue("frame1Far", FrameAddressRegister, 32'h0800_0004);
        checkValue("frame1Count", 32'(FrameCount), 32'd1);

        // Same frame with gaps.
        sendWord(32'h0800_0004, 1'b1);
        sendRows(Rows, 1'b0, 1'b1);
        idle(2);
        checkValue("frame2Count", 32'(FrameCount), 32'd2);

        // Desync, then restart.
        sendWord(32'hA000_0000, 1'b0);
        checkValue("desyncActive", 32'(Active), 32'd0);
        checkValue("desyncFar", FrameAddressRegister, 32'h0800_0004);
        sendWord(Sync, 1'b0);
        sendWord(32'h1000_0001, 1'b0);
        sendRows(Rows, 1'b1, 1'b0);
        idle(2);
        checkValue("frame3Count", 32'(FrameCount), 32'd3);

        // Mid-frame reset abandons the frame.
        sendWord(32'h1800_0002, 1'b0);
        sendRows(4, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0);
        idle(3);
        checkValue("abortLfs", 32'(LongFrameStrobe), 32'd0);
        checkValue("abortActive", 32'(Active), 32'd0);
        sendWord(Sync, 1'b0);
        sendWord(32'h2000_0008, 1'b0);
        sendRows(Rows, 1'b1, 1'b1);
        idle(2);
        checkValue("postAbortCount", 32'(FrameCount), 32'd1);

        // FrameCount wrap.
        force dut.FrameCount = 16'hFFFF;
        #1;
        release dut.FrameCount;
        expCount = 16'hFFFF;
        sendWord(32'h2800_0010, 1'b0);
        sendRows(Rows, 1'b1, 1'b0);
        idle(2);
        checkValue("wrapCount", 32'(FrameCount), 32'd0);

        // Random frames, desyncs and occasional aborts.
        for (int f = 0; f < 40; f++) begin
            if (hunting) begin
                repeat ($urandom_range(0, 2)) sendWord($urandom, 1'b1);
                sendWord(Sync, 1'b1);
            end
            addr = $urandom;
            if ($urandom_range(0, 5) == 0) addr[31:27] = 5'd20;
            else if (addr[31:27] == 5'd20) addr[31:27] = 5'd3;
            sendWord(addr, 1'b1);
            if (hunting) continue;
            if ($urandom_range(0, 9) == 0) begin
                sendRows($urandom_range(0, Rows - 1), 1'b1, 1'b1);
                step(1'b0, 1'b0, '0);
            end else begin
                sendRows(Rows, 1'b1, 1'b1);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
